// File: rtl/calpart_seq.sv
// Microcoded sequencer: fetches instructions from an async-read ROM and drives calpart datapath controls.
// Latency: 2 cycles per instruction (FETCH + EXEC); IN/OUT add one cycle per handshake wait.
// Backpressure: IN holds in EXEC until i_in_valid, OUT holds in EXEC until i_out_ready; PC frozen meanwhile.
//
// Ports:
//   i_clock, i_rst_n          clock, asynchronous active-low reset
//   i_start / o_busy / o_done host control (start sampled in IDLE only, done pulses in HALT EXEC)
//   o_imem_addr / i_imem_data program ROM (address = PC, data valid combinationally)
//   i_in_valid / o_in_ready   input handshake (host data on calpart datain)
//   o_out_valid / i_out_ready output handshake (calpart dataout)
//   i_q                       calpart zero flag
//   o_ie .. o_cal_value       calpart datapath controls, combinational from state and IR
module calpart_seq #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 20
) (
   input  logic               i_clock,
   input  logic               i_rst_n,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_done,
   output logic [PC_W-1:0]    o_imem_addr,
   input  logic [INSTR_W-1:0] i_imem_data,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   input  logic               i_q,
   output logic               o_ie,
   output logic               o_ze,
   output logic               o_oe,
   output logic               o_we,
   output logic               o_rae,
   output logic               o_rbe,
   output logic [1:0]         o_wa,
   output logic [1:0]         o_raa,
   output logic [1:0]         o_rba,
   output logic [2:0]         o_op,
   output logic [3:0]         o_cal_value
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2
   } state_t;

   localparam logic [3:0] CLS_NOP  = 4'd0;
   localparam logic [3:0] CLS_IN   = 4'd1;
   localparam logic [3:0] CLS_ALU  = 4'd2;
   localparam logic [3:0] CLS_OUT  = 4'd3;
   localparam logic [3:0] CLS_JZ   = 4'd4;
   localparam logic [3:0] CLS_JMP  = 4'd5;
   localparam logic [3:0] CLS_HALT = 4'd15;

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_t               r_state;
   state_t               w_state_nxt;
   logic [PC_W-1:0]      r_pc;
   logic [PC_W-1:0]      w_pc_nxt;
   logic [PC_W-1:0]      w_pc_inc;
   logic [INSTR_W-1:0]   r_ir;

   logic [3:0]           w_cls;
   logic [1:0]           w_rd;
   logic [1:0]           w_ra;
   logic [1:0]           w_rb;
   logic [2:0]           w_op;
   logic [3:0]           w_cal;
   logic [PC_W-1:0]      w_tgt;

   assign w_cls = r_ir[19:16];
   assign w_rd  = r_ir[15:14];
   assign w_ra  = r_ir[13:12];
   assign w_rb  = r_ir[11:10];
   assign w_op  = r_ir[9:7];
   assign w_cal = r_ir[6:3];
   assign w_tgt = r_ir[PC_W-1:0];

   // Natural overflow of the PC width gives the required modulo-2^PC_W wrap.
   assign w_pc_inc    = r_pc + PC_ONE;
   assign o_imem_addr = r_pc;
   assign o_busy      = (r_state != S_IDLE);

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_ir    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (r_state == S_FETCH) begin
            r_ir <= i_imem_data;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      o_done      = 1'b0;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      o_ie        = 1'b0;
      o_ze        = 1'b0;
      o_oe        = 1'b0;
      o_we        = 1'b0;
      o_rae       = 1'b0;
      o_rbe       = 1'b0;
      o_wa        = 2'd0;
      o_raa       = 2'd0;
      o_rba       = 2'd0;
      o_op        = 3'd0;
      o_cal_value = 4'd0;

      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_pc_nxt    = '0;
               w_state_nxt = S_FETCH;
            end
         end

         S_FETCH: begin
            w_state_nxt = S_EXEC;
         end

         S_EXEC: begin
            case (w_cls)
               CLS_IN: begin
                  o_in_ready = 1'b1;
                  o_ie       = 1'b1;
                  o_wa       = w_rd;
                  // Register write only on the actual transfer cycle.
                  if (i_in_valid) begin
                     o_we        = 1'b1;
                     w_pc_nxt    = w_pc_inc;
                     w_state_nxt = S_FETCH;
                  end
               end

               CLS_ALU: begin
                  o_rae       = 1'b1;
                  o_rbe       = 1'b1;
                  o_raa       = w_ra;
                  o_rba       = w_rb;
                  o_op        = w_op;
                  o_cal_value = w_cal;
                  o_we        = 1'b1;
                  o_wa        = w_rd;
                  o_ze        = 1'b1;
                  w_pc_nxt    = w_pc_inc;
                  w_state_nxt = S_FETCH;
               end

               CLS_OUT: begin
                  o_rae       = 1'b1;
                  o_rbe       = 1'b1;
                  o_raa       = w_ra;
                  o_rba       = w_rb;
                  o_op        = w_op;
                  o_cal_value = w_cal;
                  o_oe        = 1'b1;
                  o_out_valid = 1'b1;
                  if (i_out_ready) begin
                     w_pc_nxt    = w_pc_inc;
                     w_state_nxt = S_FETCH;
                  end
               end

               // Q was updated on the previous ALU edge, so it is current here.
               CLS_JZ: begin
                  w_pc_nxt    = i_q ? w_tgt : w_pc_inc;
                  w_state_nxt = S_FETCH;
               end

               CLS_JMP: begin
                  w_pc_nxt    = w_tgt;
                  w_state_nxt = S_FETCH;
               end

               // PC stays on the HALT so the host can see where execution stopped.
               CLS_HALT: begin
                  o_done      = 1'b1;
                  w_state_nxt = S_IDLE;
               end

               // NOP and the unassigned classes: advance with no datapath activity.
               default: begin
                  w_pc_nxt    = w_pc_inc;
                  w_state_nxt = S_FETCH;
               end
            endcase
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_calpart_seq.sv
module tb_calpart_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic        done;
   logic [7:0]  imem_addr;
   logic [19:0] imem_data;
   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic        q;
   logic        ie, ze, oe, we, rae, rbe;
   logic [1:0]  wa, raa, rba;
   logic [2:0]  op;
   logic [3:0]  cal;

   logic [19:0] rom [256];
   logic [30:0] obs;

   int n_tests = 0;
   int n_fail  = 0;

   calpart_seq #(.PC_W(8), .INSTR_W(20)) dut (
      .i_clock     (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .o_busy      (busy),
      .o_done      (done),
      .o_imem_addr (imem_addr),
      .i_imem_data (imem_data),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .i_q         (q),
      .o_ie        (ie),
      .o_ze        (ze),
      .o_oe        (oe),
      .o_we        (we),
      .o_rae       (rae),
      .o_rbe       (rbe),
      .o_wa        (wa),
      .o_raa       (raa),
      .o_rba       (rba),
      .o_op        (op),
      .o_cal_value (cal)
   );

   assign imem_data = rom[imem_addr];
   assign obs = {busy, done, imem_addr, in_ready, out_valid, ie, ze, oe, we, rae, rbe,
                 wa, raa, rba, op, cal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observation vector: {busy, done, addr[7:0], ctl[20:0]}
   function automatic logic [30:0] V(input logic b, input logic d, input logic [7:0] a,
                                     input logic [20:0] c);
      return {b, d, a, c};
   endfunction

   function automatic logic [30:0] v_idle(input logic [7:0] a);
      return V(1'b0, 1'b0, a, 21'd0);
   endfunction

   function automatic logic [30:0] v_fetch(input logic [7:0] a);
      return V(1'b1, 1'b0, a, 21'd0);
   endfunction

   // ctl = {in_ready, out_valid, ie, ze, oe, we, rae, rbe, wa, raa, rba, op, cal}
   function automatic logic [20:0] c_in(input logic [1:0] rd, input logic w);
      return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, w, 1'b0, 1'b0, rd, 2'd0, 2'd0, 3'd0, 4'd0};
   endfunction

   function automatic logic [20:0] c_alu(input logic [1:0] rd, input logic [1:0] ra,
                                         input logic [1:0] rb, input logic [2:0] o,
                                         input logic [3:0] c);
      return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, rd, ra, rb, o, c};
   endfunction

   function automatic logic [20:0] c_out(input logic [1:0] ra, input logic [1:0] rb,
                                         input logic [2:0] o, input logic [3:0] c);
      return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, ra, rb, o, c};
   endfunction

   function automatic logic [19:0] enc(input logic [3:0] cls, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb,
                                       input logic [2:0] o, input logic [3:0] c);
      return {cls, rd, ra, rb, o, c, 3'b000};
   endfunction

   function automatic logic [19:0] encj(input logic [3:0] cls, input logic [7:0] t);
      return {cls, 8'h00, t};
   endfunction

   task automatic chk(input string nm, input logic [30:0] exp);
      #1;
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, obs, exp);
      end
   endtask

   // One cycle: drive inputs just after the falling edge, then compare.
   task automatic cyc(input logic s, input logic iv, input logic orr, input logic qq,
                      input string nm, input logic [30:0] exp);
      @(negedge clk);
      start = s; in_valid = iv; out_ready = orr; q = qq;
      chk(nm, exp);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 20'h0;
   endtask

   typedef struct {
      logic        s;
      logic        iv;
      logic        orr;
      logic        qq;
      logic [30:0] exp;
   } row_t;

   row_t tbl [12];

   localparam logic [19:0] HALT = 20'hF0000;

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; q = 1'b0;
      clear_rom();
      #3;
      chk("reset_state", 31'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Main program: IN r0; IN r1; ALU r2=r0 add r1; OUT r2; HALT
      rom[0] = enc(4'd1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
      rom[1] = enc(4'd1, 2'd1, 2'd0, 2'd0, 3'd0, 4'd0);
      rom[2] = enc(4'd2, 2'd2, 2'd0, 2'd1, 3'd2, 4'd0);
      rom[3] = enc(4'd3, 2'd0, 2'd2, 2'd0, 3'd0, 4'd0);
      rom[4] = HALT;

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, v_idle(8'd0)};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, v_fetch(8'd0)};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, V(1'b1, 1'b0, 8'd0, c_in(2'd0, 1'b1))};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, v_fetch(8'd1)};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, V(1'b1, 1'b0, 8'd1, c_in(2'd1, 1'b1))};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, v_fetch(8'd2)};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0,
                  V(1'b1, 1'b0, 8'd2, c_alu(2'd2, 2'd0, 2'd1, 3'd2, 4'd0))};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, v_fetch(8'd3)};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0,
                  V(1'b1, 1'b0, 8'd3, c_out(2'd2, 2'd0, 3'd0, 4'd0))};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, v_fetch(8'd4)};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, V(1'b1, 1'b1, 8'd4, 21'd0)};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, v_idle(8'd4)};

      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].s, tbl[i].iv, tbl[i].orr, tbl[i].qq, $sformatf("prog_vec%0d", i), tbl[i].exp);
      end

      // IN with four wait cycles: we stays low, PC held, transfer on first valid.
      clear_rom();
      rom[0] = enc(4'd1, 2'd3, 2'd0, 2'd0, 3'd0, 4'd0);
      rom[1] = HALT;
      cyc(1, 0, 0, 0, "inw_idle", v_idle(8'd4));
      cyc(0, 0, 0, 0, "inw_fetch", v_fetch(8'd0));
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, $sformatf("inw_wait%0d", i), V(1'b1, 1'b0, 8'd0, c_in(2'd3, 1'b0)));
      end
      cyc(0, 1, 0, 0, "inw_xfer", V(1'b1, 1'b0, 8'd0, c_in(2'd3, 1'b1)));
      cyc(0, 1, 0, 0, "inw_next_fetch", v_fetch(8'd1));
      cyc(0, 0, 0, 0, "inw_halt", V(1'b1, 1'b1, 8'd1, 21'd0));

      // ALU then JZ, taken and not taken.
      clear_rom();
      rom[0]     = enc(4'd2, 2'd0, 2'd1, 2'd1, 3'd1, 4'd0);
      rom[1]     = encj(4'd4, 8'h20);
      rom[2]     = HALT;
      rom[8'h20] = HALT;
      for (int t = 0; t < 2; t++) begin
         cyc(1, 0, 0, 0, "jz_idle", v_idle(t == 0 ? 8'd1 : 8'h20));
         cyc(0, 0, 0, 0, "jz_fetch_alu", v_fetch(8'd0));
         cyc(0, 0, 0, 0, "jz_exec_alu",
             V(1'b1, 1'b0, 8'd0, c_alu(2'd0, 2'd1, 2'd1, 3'd1, 4'd0)));
         cyc(0, 0, 0, 0, "jz_fetch", v_fetch(8'd1));
         cyc(0, 0, 0, (t == 0), "jz_exec", V(1'b1, 1'b0, 8'd1, 21'd0));
         cyc(0, 0, 0, 0, t == 0 ? "jz_taken_addr" : "jz_fall_addr",
             v_fetch(t == 0 ? 8'h20 : 8'd2));
         cyc(0, 0, 0, 0, "jz_halt", V(1'b1, 1'b1, t == 0 ? 8'h20 : 8'd2, 21'd0));
      end

      // JMP to 0xFF holding NOP: PC wraps to 0.
      clear_rom();
      rom[0] = encj(4'd5, 8'hFF);
      cyc(1, 0, 0, 0, "wrap_idle", v_idle(8'd2));
      cyc(0, 0, 0, 0, "wrap_fetch0", v_fetch(8'd0));
      cyc(0, 0, 0, 0, "wrap_jmp", V(1'b1, 1'b0, 8'd0, 21'd0));
      cyc(0, 0, 0, 0, "wrap_fetchff", v_fetch(8'hFF));
      cyc(0, 0, 0, 0, "wrap_nop", V(1'b1, 1'b0, 8'hFF, 21'd0));
      cyc(0, 0, 0, 0, "wrap_to_zero", v_fetch(8'h00));
      #1 rst_n = 1'b0;
      chk("wrap_reset", 31'd0);

      // Async reset in the middle of an OUT wait.
      clear_rom();
      rom[0] = enc(4'd3, 2'd0, 2'd1, 2'd2, 3'd5, 4'hA);
      rom[1] = HALT;
      cyc(0, 0, 0, 0, "rst_held", 31'd0);
      rst_n = 1'b1;
      cyc(1, 0, 0, 0, "out_idle", v_idle(8'd0));
      cyc(0, 0, 0, 0, "out_fetch", v_fetch(8'd0));
      cyc(0, 0, 0, 0, "out_wait",
          V(1'b1, 1'b0, 8'd0, c_out(2'd1, 2'd2, 3'd5, 4'hA)));
      #1 rst_n = 1'b0;
      chk("out_async_rst", 31'd0);
      cyc(0, 0, 0, 0, "out_rst_hold", 31'd0);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0, "out_after_rst", v_idle(8'd0));
      cyc(1, 0, 0, 0, "out_restart_idle", v_idle(8'd0));
      cyc(0, 0, 0, 0, "out_restart_fetch", v_fetch(8'd0));
      cyc(0, 0, 1, 0, "out_xfer",
          V(1'b1, 1'b0, 8'd0, c_out(2'd1, 2'd2, 3'd5, 4'hA)));
      cyc(0, 0, 0, 0, "out_next", v_fetch(8'd1));
      cyc(0, 0, 0, 0, "out_halt", V(1'b1, 1'b1, 8'd1, 21'd0));

      // Start while busy and a class-9 instruction with every field set.
      clear_rom();
      rom[0] = 20'h9FFFF;
      rom[1] = HALT;
      cyc(1, 0, 0, 0, "c9_idle", v_idle(8'd1));
      cyc(1, 1, 1, 1, "c9_fetch", v_fetch(8'd0));
      cyc(1, 1, 1, 1, "c9_exec", V(1'b1, 1'b0, 8'd0, 21'd0));
      cyc(1, 1, 1, 1, "c9_fetch_halt", v_fetch(8'd1));
      cyc(1, 0, 0, 0, "c9_halt_start", V(1'b1, 1'b1, 8'd1, 21'd0));
      cyc(0, 0, 0, 0, "c9_no_capture", v_idle(8'd1));
      cyc(0, 0, 0, 0, "c9_still_idle", v_idle(8'd1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no summary by 50000 want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/calpart_seq.md
# calpart_seq

Microcoded sequencer that drives the control inputs of the `calpart` register-file/ALU datapath. It fetches fixed-width instructions from an external asynchronous-read program ROM and decodes each into one cycle of datapath control. It also handles input/output valid-ready handshakes and a conditional branch on the datapath zero flag `Q`. It sits between the top-level host (start/done) and one `calpart` instance.

## Interface
- `PC_W`, 8: program counter width; ROM depth is 2^PC_W.
- `INSTR_W`, 20: instruction width, fixed format below.

- `clock`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin execution at PC 0; sampled in IDLE only
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when HALT completes
- `imem_addr`  out  PC_W  ROM address, equal to the PC
- `imem_data`  in  INSTR_W  ROM word, combinationally valid for `imem_addr`
- `in_valid`  in  1  host data present on the `calpart` `datain`
- `in_ready`  out  1  sequencer accepts input this cycle
- `out_valid`  out  1  `calpart` `dataout` is valid
- `out_ready`  in  1  host consumes output
- `q`  in  1  zero flag `Q` from `calpart`
- `ie`, `ze`, `oe`, `we`, `rae`, `rbe`  out  1 each  datapath controls
- `wa`, `raa`, `rba`  out  2 each  register addresses
- `op`  out  3  ALU opcode
- `cal_value`  out  4  ALU immediate

## Operation
- Instruction fields:
  - [19:16] class
  - [15:14] rd
  - [13:12] ra
  - [11:10] rb
  - [9:7] op
  - [6:3] cal
  - [2:0] reserved, ignored
  - For jumps, the target is [PC_W-1:0].
- Classes:
  - 0 NOP
  - 1 IN
  - 2 ALU
  - 3 OUT
  - 4 JZ
  - 5 JMP
  - 15 HALT
  - 6–14 execute as NOP.
- States:
  - IDLE: `start` loads PC=0, go to FETCH.
  - FETCH: latch `imem_data` into IR, go to EXEC.
  - EXEC: drive controls decoded from IR, then advance per class.
- EXEC behaviour per class:
  - NOP: PC+1, go to FETCH.
  - IN: `in_ready`=1, `ie`=1, `wa`=rd. `we`=1 only when `in_valid`=1. On that transfer, PC+1 and go to FETCH; otherwise stay in EXEC.
  - ALU: `rae`=`rbe`=1, `raa`=ra, `rba`=rb, `op`, `cal_value`=cal, `we`=1, `wa`=rd, `ze`=1. Then PC+1, go to FETCH.
  - OUT: `rae`=`rbe`=1, `raa`=ra, `rba`=rb, `op`, `cal_value`=cal, `oe`=1, `out_valid`=1. Hold until `out_ready`=1, then PC+1 and go to FETCH. `we`=0 throughout.
  - JZ: if `q`=1 PC=target, else PC+1; go to FETCH.
  - JMP: PC=target, go to FETCH.
  - HALT: `done`=1 for one cycle, go to IDLE. PC is unchanged.
- Decode outputs (all datapath controls, `in_ready`, `out_valid`) are combinational from state and IR. They are 0 in IDLE and FETCH, and any field not listed for a class is 0.
- PC arithmetic is modulo 2^PC_W: PC+1 from 2^PC_W−1 wraps to 0.
- `start` while busy is ignored. `start` and HALT in the same cycle: HALT completes and `start` is not captured; a new `start` is needed in IDLE.

## Timing
- Reset (async, `rst_n`=0) clears: state=IDLE, PC=0, IR=0, and all outputs to 0 (`busy`, `done`, `imem_addr`, `in_ready`, `out_valid`, all controls). This applies immediately, including mid-instruction.
- Non-waiting instructions take 2 cycles (FETCH + EXEC).
- IN and OUT take 2 + N cycles, where N is the number of wait cycles before the handshake.
- `ze` asserted in the ALU EXEC cycle updates `calpart` `Q` on that same edge. A JZ directly following therefore sees the new flag in its EXEC cycle; no bubble is needed.
- `busy` rises the cycle after `start` is sampled and falls the cycle after the `done` pulse.
- `done` is high exactly in the HALT EXEC cycle.

## Test plan
- Program: IN r0; IN r1; ALU r2=r0 op=add r1; OUT ra=r2; HALT. Inputs 3, 5 -> `dataout`=8 with `out_valid`; `done` pulse on cycle 10 after `start` (zero waits).
- `in_valid` held low for 4 cycles during IN -> `we` stays 0 and PC is held; the transfer occurs on the first `in_valid` cycle; total latency 6.
- ALU producing 0, then JZ target=0x20 -> next `imem_addr`=0x20. Same sequence with a nonzero result -> `imem_addr`=JZ PC+1.
- JMP to 0xFF holding NOP -> PC wraps to 0x00 after that NOP executes.
- `rst_n` pulsed low during an OUT wait -> `oe`, `out_valid`, `busy` drop to 0 asynchronously; after release the state is IDLE and `start` restarts from PC 0.
- `start` asserted while busy, and class 9 instruction -> no restart occurs; class 9 executes in 2 cycles with all controls 0.
